conv3x3_filter: RTL and testbench

Pipelined 3x3 convolution stage that sits directly downstream of the four-line-buffer image controller. It consumes one 72-bit 3x3 pixel window per valid cycle and produces one filtered 8-bit pixel per window. It offers four runtime-selectable kernels: passthrough, Gaussian blur, sharpen and Sobel magnitude. It also generates a per-line end marker so the DMA/stream side can frame each 640-pixel output line.

---
 rtl/conv3x3_filter_pkg.sv | 25 ++
 rtl/conv3x3_filter_sat_clamp_u8.sv | 23 ++
 rtl/conv3x3_filter.sv | 179 +++++++++++++++++
 tb/tb_conv3x3_filter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_filter_pkg
// Brief    : Shared kernel-mode codes, pixel/window widths and window access.
// Revision : 1.0
// ============================================================================
package conv3x3_filter_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 72;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_SOBEL = 2'd3;

    // Row 0 is the oldest line, column 0 the leftmost pixel.
    function automatic logic [PIX_W-1:0] get_pix(input logic [WIN_W-1:0] win,
                                                 input int unsigned     r,
                                                 input int unsigned     c);
        return win[PIX_W*(3*r+c) +: PIX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_filter_sat_clamp_u8.sv
`default_nettype none
// ============================================================================
// Module   : sat_clamp_u8
// Brief    : Clamps a signed 12-bit value into the unsigned 8-bit range 0..255.
// Revision : 1.0
// ============================================================================
module sat_clamp_u8 (
    input  logic signed [11:0] val_i,
    output logic        [7:0]  val_o
);

    always_comb begin
        if (val_i[11]) begin
            val_o = 8'd0;
        end else if (val_i > 12'sd255) begin
            val_o = 8'd255;
        end else begin
            val_o = val_i[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_filter.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_filter
// Brief    : 3-stage 3x3 convolution (pass/Gaussian/sharpen/Sobel) with
//            per-line end marker on the output stream.
// Revision : 1.0
// ============================================================================
module conv3x3_filter
    import conv3x3_filter_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int CNT_W      = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIN_W-1:0]   i_pixel_data,
    input  logic               i_pixel_data_valid,
    input  logic [1:0]         i_mode,
    output logic [PIX_W-1:0]   o_pixel_data,
    output logic               o_pixel_data_valid,
    output logic               o_line_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WIDTH - 1);

    // ------------------------------------------------------------------
    // Stage 1: weighted row sums (1,2,1), outer column sums, sharpen terms
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] p [3][3];

    logic [9:0]  row0_d, row1_d, row2_d, col0_d, col2_d, nsum_d;
    logic [10:0] c5_d;

    logic        s1_valid_q;
    logic [1:0]  s1_mode_q;
    logic [7:0]  s1_center_q;
    logic [9:0]  s1_row0_q, s1_row1_q, s1_row2_q;
    logic [9:0]  s1_col0_q, s1_col2_q;
    logic [9:0]  s1_nsum_q;
    logic [10:0] s1_c5_q;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p[r][c] = get_pix(i_pixel_data, r, c);
            end
        end
        row0_d = {2'b00, p[0][0]} + {1'b0, p[0][1], 1'b0} + {2'b00, p[0][2]};
        row1_d = {2'b00, p[1][0]} + {1'b0, p[1][1], 1'b0} + {2'b00, p[1][2]};
        row2_d = {2'b00, p[2][0]} + {1'b0, p[2][1], 1'b0} + {2'b00, p[2][2]};
        col0_d = {2'b00, p[0][0]} + {1'b0, p[1][0], 1'b0} + {2'b00, p[2][0]};
        col2_d = {2'b00, p[0][2]} + {1'b0, p[1][2], 1'b0} + {2'b00, p[2][2]};
        nsum_d = {2'b00, p[0][1]} + {2'b00, p[1][0]}
               + {2'b00, p[1][2]} + {2'b00, p[2][1]};
        c5_d   = {1'b0, p[1][1], 2'b00} + {3'b000, p[1][1]};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_PASS;
            s1_center_q <= '0;
            s1_row0_q   <= '0;
            s1_row1_q   <= '0;
            s1_row2_q   <= '0;
            s1_col0_q   <= '0;
            s1_col2_q   <= '0;
            s1_nsum_q   <= '0;
            s1_c5_q     <= '0;
        end else begin
            s1_valid_q  <= i_pixel_data_valid;
            s1_mode_q   <= i_mode;
            s1_center_q <= p[1][1];
            s1_row0_q   <= row0_d;
            s1_row1_q   <= row1_d;
            s1_row2_q   <= row2_d;
            s1_col0_q   <= col0_d;
            s1_col2_q   <= col2_d;
            s1_nsum_q   <= nsum_d;
            s1_c5_q     <= c5_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: full kernel sums and gradient magnitudes
    // ------------------------------------------------------------------
    logic        [11:0] gauss_d;
    logic signed [11:0] sharp_d;
    logic signed [10:0] gx_d, gy_d;
    logic        [10:0] absgx_d, absgy_d;

    logic               s2_valid_q;
    logic        [1:0]  s2_mode_q;
    logic        [7:0]  s2_center_q;
    logic        [11:0] s2_gauss_q;
    logic signed [11:0] s2_sharp_q;
    logic        [10:0] s2_absgx_q, s2_absgy_q;

    always_comb begin
        gauss_d = {2'b00, s1_row0_q} + {1'b0, s1_row1_q, 1'b0} + {2'b00, s1_row2_q};
        sharp_d = $signed({1'b0, s1_c5_q}) - $signed({2'b00, s1_nsum_q});
        gx_d    = $signed({1'b0, s1_col2_q}) - $signed({1'b0, s1_col0_q});
        gy_d    = $signed({1'b0, s1_row2_q}) - $signed({1'b0, s1_row0_q});
        absgx_d = gx_d[10] ? (~gx_d + 11'd1) : gx_d;
        absgy_d = gy_d[10] ? (~gy_d + 11'd1) : gy_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= MODE_PASS;
            s2_center_q <= '0;
            s2_gauss_q  <= '0;
            s2_sharp_q  <= '0;
            s2_absgx_q  <= '0;
            s2_absgy_q  <= '0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_center_q <= s1_center_q;
            s2_gauss_q  <= gauss_d;
            s2_sharp_q  <= sharp_d;
            s2_absgx_q  <= absgx_d;
            s2_absgy_q  <= absgy_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: mode select, normalise/clamp, line framing
    // ------------------------------------------------------------------
    logic        [10:0] sobel_sum;
    logic signed [11:0] sobel_s;
    logic        [7:0]  sharp_u8, sobel_u8;
    logic        [7:0]  pix_d;
    logic [CNT_W-1:0]   cnt_q;

    // |Gx|+|Gy| tops out at 2040, so the zero-extended value is never negative.
    assign sobel_sum = s2_absgx_q + s2_absgy_q;
    assign sobel_s   = $signed({1'b0, sobel_sum});

    sat_clamp_u8 u_sat_sharp (
        .val_i (s2_sharp_q),
        .val_o (sharp_u8)
    );

    sat_clamp_u8 u_sat_sobel (
        .val_i (sobel_s),
        .val_o (sobel_u8)
    );

    always_comb begin
        pix_d = s2_center_q;
        case (s2_mode_q)
            MODE_GAUSS: pix_d = 8'(s2_gauss_q >> 4);
            MODE_SHARP: pix_d = sharp_u8;
            MODE_SOBEL: pix_d = sobel_u8;
            default:    pix_d = s2_center_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_line_end         <= 1'b0;
            cnt_q              <= '0;
        end else begin
            o_pixel_data_valid <= s2_valid_q;
            o_line_end         <= 1'b0;
            if (s2_valid_q) begin
                o_pixel_data <= pix_d;
                o_line_end   <= (cnt_q == CNT_LAST);
                cnt_q        <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_filter
// Brief    : Randomised self-checking bench for conv3x3_filter against a
//            kernel-level arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_conv3x3_filter;

    localparam int LW = 640;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [71:0] win;
    logic        win_v;
    logic [1:0]  mode;
    logic [7:0]  px;
    logic        px_v;
    logic        le;

    always #5 clk = ~clk;

    conv3x3_filter #(
        .LINE_WIDTH (LW),
        .CNT_W      (10)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pixel_data       (win),
        .i_pixel_data_valid (win_v),
        .i_mode             (mode),
        .o_pixel_data       (px),
        .o_pixel_data_valid (px_v),
        .o_line_end         (le)
    );

    typedef struct {
        int pix;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   stepn   = 0;
    int   out_cnt = 0;
    int   le_cnt  = 0;

    function automatic int ref_pix(input logic [71:0] w, input logic [1:0] m);
        int p  [3][3];
        int kg [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
        int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        int g  = 0;
        int gx = 0;
        int gy = 0;
        int s;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p[r][c] = int'(w[8*(3*r+c) +: 8]);
                g  += kg[r][c] * p[r][c];
                gx += kx[r][c] * p[r][c];
                gy += ky[r][c] * p[r][c];
            end
        end
        case (m)
            2'd0: s = p[1][1];
            2'd1: s = g / 16;
            2'd2: s = 5 * p[1][1] - (p[0][1] + p[1][0] + p[1][2] + p[2][1]);
            default: s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        endcase
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(0, 7))
                0:       w[8*i +: 8] = 8'd0;
                1:       w[8*i +: 8] = 8'd255;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, stepn);
        end
    endtask

    // One clock: drive a window (or bubble), then check what the DUT shows.
    task automatic step(input logic v, input logic [71:0] w, input logic [1:0] m,
                        input int exp_pix);
        exp_t e;
        bit   ev;
        win_v = v;
        win   = w;
        mode  = m;
        if (v) begin
            e.pix = (exp_pix < 0) ? ref_pix(w, m) : exp_pix;
            e.due = stepn + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        ev = (q.size() > 0) && (q[0].due == stepn);
        chk("valid", int'(px_v), int'(ev));
        if (le) le_cnt++;
        if (ev) begin
            e = q.pop_front();
            if (px_v) begin
                chk("pixel", int'(px), e.pix);
                chk("line_end", int'(le), int'(out_cnt == LW - 1));
                out_cnt = (out_cnt + 1) % LW;
            end
        end else if (!px_v) begin
            chk("le_bubble", int'(le), 0);
        end
        stepn++;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 72'd0, 2'd0, -1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        win_v = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(px_v), 0);
        chk("rst_pixel", int'(px), 0);
        chk("rst_le", int'(le), 0);
        q.delete();
        out_cnt = 0;
        rst_n = 1'b1;
        stepn++;
    endtask

    task automatic run_windows(input int n, input int max_gap, input bit rnd_mode);
        for (int i = 0; i < n; i++) begin
            step(1'b1, rnd_win(), rnd_mode ? 2'($urandom_range(0, 3)) : 2'd3, -1);
            if (max_gap > 0) drain($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        logic [71:0] w;
        rst_n = 1'b0;
        win   = '0;
        win_v = 1'b0;
        mode  = 2'd0;
        do_reset();

        // Flat field through each kernel.
        for (int m = 0; m < 4; m++) begin
            step(1'b1, {9{8'd100}}, 2'(m), (m == 3) ? 0 : 100);
        end
        drain(3);

        // Sharpen clamp at both ends.
        w = 72'd0;
        w[39:32] = 8'd255;
        step(1'b1, w, 2'd2, 255);
        w = {9{8'd255}};
        w[39:32] = 8'd0;
        step(1'b1, w, 2'd2, 0);

        // Vertical edge: left and middle columns 0, right column 255.
        w = 72'd0;
        for (int r = 0; r < 3; r++) w[8*(3*r+2) +: 8] = 8'd255;
        step(1'b1, w, 2'd3, 255);
        step(1'b1, w, 2'd1, -1);
        drain(3);

        // Mode change between consecutive windows.
        step(1'b1, rnd_win(), 2'd1, -1);
        step(1'b1, rnd_win(), 2'd3, -1);
        drain(3);

        run_windows(200, 2, 1'b1);
        drain(4);

        // Two full lines with random gaps.
        do_reset();
        le_cnt = 0;
        run_windows(1280, 5, 1'b1);
        drain(4);
        chk("le_count_2lines", le_cnt, 2);

        // Reset with the line counter at 300 and two windows in flight.
        do_reset();
        run_windows(300, 0, 1'b1);
        drain(4);
        step(1'b1, rnd_win(), 2'd0, -1);
        step(1'b1, rnd_win(), 2'd1, -1);
        q.delete();
        do_reset();
        le_cnt = 0;
        drain(4);
        run_windows(LW, 0, 1'b1);
        drain(4);
        chk("le_count_after_rst", le_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
